// File: rtl/risc8_pkg.sv
// Shared widths, forwarding source codes and flag bit positions for the RISC-8 core.
package risc8_pkg;
    localparam int DW   = 8;
    localparam int RAW  = 3;
    localparam int SELW = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXM = 2'd1;
    localparam logic [1:0] FWD_MWB = 2'd2;

    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_B = 1;
    localparam int FLG_P = 0;
endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector for one source register.
// Picks the youngest in-flight producer of rs; r0 is hardwired to zero.
module fwd_mux
    import risc8_pkg::*;
(
    input  logic [RAW-1:0] rs,
    input  logic [DW-1:0]  rf_data,
    input  logic           exm_valid,
    input  logic           exm_reg_we,
    input  logic [RAW-1:0] exm_rd_addr,
    input  logic [DW-1:0]  exm_result,
    input  logic           mwb_valid,
    input  logic           mwb_reg_we,
    input  logic [RAW-1:0] mwb_rd_addr,
    input  logic [DW-1:0]  mwb_result,
    output logic [DW-1:0]  data,
    output logic [1:0]     src
);
    logic rs_nonzero;
    logic exm_hit;
    logic mwb_hit;

    assign rs_nonzero = (rs != '0);
    assign exm_hit    = exm_valid & exm_reg_we & (exm_rd_addr == rs) & rs_nonzero;
    assign mwb_hit    = mwb_valid & mwb_reg_we & (mwb_rd_addr == rs) & rs_nonzero;

    // EX/MEM holds the newer value, so it outranks MEM/WB
    always_comb begin
        data = rf_data;
        src  = FWD_RF;
        if (!rs_nonzero) begin
            data = '0;
            src  = FWD_RF;
        end else if (exm_hit) begin
            data = exm_result;
            src  = FWD_EXM;
        end else if (mwb_hit) begin
            data = mwb_result;
            src  = FWD_MWB;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and the architectural flag register.
module id_ex_stage
    import risc8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs1_addr,
    input  logic [RAW-1:0]  id_rs2_addr,
    input  logic [DW-1:0]   id_rs1_data,
    input  logic [DW-1:0]   id_rs2_data,
    input  logic [DW-1:0]   id_imm,
    input  logic            id_use_imm,
    input  logic [SELW-1:0] id_alu_sel,
    input  logic [RAW-1:0]  id_rd_addr,
    input  logic            id_reg_we,
    input  logic            id_flag_we,
    input  logic            stall,
    input  logic            flush,
    input  logic            exm_valid,
    input  logic            exm_reg_we,
    input  logic [RAW-1:0]  exm_rd_addr,
    input  logic [DW-1:0]   exm_result,
    input  logic            mwb_valid,
    input  logic            mwb_reg_we,
    input  logic [RAW-1:0]  mwb_rd_addr,
    input  logic [DW-1:0]   mwb_result,
    input  logic [3:0]      alu_flag,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_a,
    output logic [DW-1:0]   ex_b,
    output logic [SELW-1:0] ex_alu_sel,
    output logic [RAW-1:0]  ex_rd_addr,
    output logic            ex_reg_we,
    output logic            ex_flag_we,
    output logic [1:0]      fwd_a_src,
    output logic [1:0]      fwd_b_src,
    output logic [3:0]      flags_q
);
    logic [DW-1:0] fwd_a_data;
    logic [DW-1:0] fwd_b_data;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic [DW-1:0] b_next;
    logic [1:0]    b_src_next;

    fwd_mux u_fwd_a (
        .rs          (id_rs1_addr),
        .rf_data     (id_rs1_data),
        .exm_valid   (exm_valid),
        .exm_reg_we  (exm_reg_we),
        .exm_rd_addr (exm_rd_addr),
        .exm_result  (exm_result),
        .mwb_valid   (mwb_valid),
        .mwb_reg_we  (mwb_reg_we),
        .mwb_rd_addr (mwb_rd_addr),
        .mwb_result  (mwb_result),
        .data        (fwd_a_data),
        .src         (fwd_a_sel)
    );

    fwd_mux u_fwd_b (
        .rs          (id_rs2_addr),
        .rf_data     (id_rs2_data),
        .exm_valid   (exm_valid),
        .exm_reg_we  (exm_reg_we),
        .exm_rd_addr (exm_rd_addr),
        .exm_result  (exm_result),
        .mwb_valid   (mwb_valid),
        .mwb_reg_we  (mwb_reg_we),
        .mwb_rd_addr (mwb_rd_addr),
        .mwb_result  (mwb_result),
        .data        (fwd_b_data),
        .src         (fwd_b_sel)
    );

    // An immediate b operand bypasses rs2 forwarding entirely
    assign b_next     = id_use_imm ? id_imm : fwd_b_data;
    assign b_src_next = id_use_imm ? FWD_RF : fwd_b_sel;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid   <= 1'b0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_alu_sel <= '0;
            ex_rd_addr <= '0;
            ex_reg_we  <= 1'b0;
            ex_flag_we <= 1'b0;
            fwd_a_src  <= FWD_RF;
            fwd_b_src  <= FWD_RF;
        end else if (!stall) begin
            ex_valid   <= id_valid;
            ex_a       <= fwd_a_data;
            ex_b       <= b_next;
            ex_alu_sel <= id_alu_sel;
            ex_rd_addr <= id_rd_addr;
            ex_reg_we  <= id_valid & id_reg_we;
            ex_flag_we <= id_valid & id_flag_we;
            fwd_a_src  <= fwd_a_sel;
            fwd_b_src  <= b_src_next;
        end
    end

    // Flags commit as the EX instruction leaves; a flush only kills the incoming one
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (ex_valid && ex_flag_we && !stall) begin
            flags_q <= alu_flag;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed plan cases followed by random traffic.
module tb_id_ex_stage;
    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [7:0] id_rs1_data, id_rs2_data, id_imm;
    logic       id_use_imm;
    logic [3:0] id_alu_sel;
    logic       id_reg_we, id_flag_we;
    logic       stall, flush;
    logic       exm_valid, exm_reg_we;
    logic [2:0] exm_rd_addr;
    logic [7:0] exm_result;
    logic       mwb_valid, mwb_reg_we;
    logic [2:0] mwb_rd_addr;
    logic [7:0] mwb_result;
    logic [3:0] alu_flag;
    logic       ex_valid;
    logic [7:0] ex_a, ex_b;
    logic [3:0] ex_alu_sel;
    logic [2:0] ex_rd_addr;
    logic       ex_reg_we, ex_flag_we;
    logic [1:0] fwd_a_src, fwd_b_src;
    logic [3:0] flags_q;

    typedef struct {
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [2:0] rd;
        logic       rwe;
        logic       fwe;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] flags;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    bit   stim_done = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_sel(id_alu_sel),
        .id_rd_addr(id_rd_addr), .id_reg_we(id_reg_we), .id_flag_we(id_flag_we),
        .stall(stall), .flush(flush),
        .exm_valid(exm_valid), .exm_reg_we(exm_reg_we),
        .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .mwb_valid(mwb_valid), .mwb_reg_we(mwb_reg_we),
        .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
        .alu_flag(alu_flag),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_sel(ex_alu_sel),
        .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_flag_we(ex_flag_we),
        .fwd_a_src(fwd_a_src), .fwd_b_src(fwd_b_src), .flags_q(flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rule: newest producer wins, r0 is always zero
    function automatic void resolve(input logic [2:0] rs, input logic [7:0] rf,
                                    output logic [7:0] val, output logic [1:0] src);
        val = rf;
        src = 2'd0;
        if (rs == 3'd0) begin
            val = 8'h00;
        end else if (exm_valid && exm_reg_we && exm_rd_addr == rs) begin
            val = exm_result;
            src = 2'd1;
        end else if (mwb_valid && mwb_reg_we && mwb_rd_addr == rs) begin
            val = mwb_result;
            src = 2'd2;
        end
    endfunction

    function automatic exp_t zero_ex(input logic [3:0] flags);
        exp_t z;
        z.v = 0; z.a = 0; z.b = 0; z.sel = 0; z.rd = 0;
        z.rwe = 0; z.fwe = 0; z.sa = 0; z.sb = 0; z.flags = flags;
        return z;
    endfunction

    // Drive happens before this is called; model the state after the next rising edge
    task automatic applyStimulus();
        exp_t nx;
        logic [7:0] va, vb;
        logic [1:0] sa, sb;
        nx = model;
        if (rst) begin
            nx = zero_ex(4'h0);
        end else begin
            if (model.v && model.fwe && !stall) nx.flags = alu_flag;
            if (flush) begin
                nx = zero_ex(nx.flags);
            end else if (!stall) begin
                resolve(id_rs1_addr, id_rs1_data, va, sa);
                resolve(id_rs2_addr, id_rs2_data, vb, sb);
                if (id_use_imm) begin
                    vb = id_imm;
                    sb = 2'd0;
                end
                nx.v = id_valid; nx.a = va; nx.b = vb; nx.sel = id_alu_sel;
                nx.rd = id_rd_addr; nx.rwe = id_valid && id_reg_we;
                nx.fwe = id_valid && id_flag_we; nx.sa = sa; nx.sb = sb;
            end
        end
        model = nx;
        exp_q.push_back(nx);
    endtask

    task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("ex_valid",   {7'b0, ex_valid},   {7'b0, e.v});
        checkField("ex_a",       ex_a,               e.a);
        checkField("ex_b",       ex_b,               e.b);
        checkField("ex_alu_sel", {4'b0, ex_alu_sel}, {4'b0, e.sel});
        checkField("ex_rd_addr", {5'b0, ex_rd_addr}, {5'b0, e.rd});
        checkField("ex_reg_we",  {7'b0, ex_reg_we},  {7'b0, e.rwe});
        checkField("ex_flag_we", {7'b0, ex_flag_we}, {7'b0, e.fwe});
        checkField("fwd_a_src",  {6'b0, fwd_a_src},  {6'b0, e.sa});
        checkField("fwd_b_src",  {6'b0, fwd_b_src},  {6'b0, e.sb});
        checkField("flags_q",    {4'b0, flags_q},    {4'b0, e.flags});
    endtask

    task automatic setIdle();
        rst = 0; id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0;
        id_alu_sel = 0; id_rd_addr = 0; id_reg_we = 0; id_flag_we = 0;
        stall = 0; flush = 0; exm_valid = 0; exm_reg_we = 0; exm_rd_addr = 0;
        exm_result = 0; mwb_valid = 0; mwb_reg_we = 0; mwb_rd_addr = 0;
        mwb_result = 0; alu_flag = 0;
    endtask

    task automatic loadInstr(input logic [2:0] rs1, input logic [7:0] d1,
                             input logic [2:0] rs2, input logic [7:0] d2,
                             input logic [2:0] rd, input logic fwe);
        id_valid = 1; id_rs1_addr = rs1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_data = d2; id_rd_addr = rd;
        id_reg_we = 1; id_flag_we = fwe; id_alu_sel = 4'h0; id_use_imm = 0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        setIdle();
    endtask

    // Monitor: the stage presents a new state every cycle, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        model = zero_ex(4'h0);
        setIdle();
        rst = 1;
        applyStimulus();
        nextCycle(); rst = 1; applyStimulus();

        nextCycle(); loadInstr(3'd1, 8'h11, 3'd2, 8'h22, 3'd3, 0); applyStimulus();

        nextCycle(); loadInstr(3'd3, 8'h33, 3'd4, 8'h44, 3'd5, 0);
        exm_valid = 1; exm_reg_we = 1; exm_rd_addr = 3'd3; exm_result = 8'hA5;
        mwb_valid = 1; mwb_reg_we = 1; mwb_rd_addr = 3'd3; mwb_result = 8'h5A;
        applyStimulus();
        nextCycle(); loadInstr(3'd3, 8'h33, 3'd4, 8'h44, 3'd5, 0);
        mwb_valid = 1; mwb_reg_we = 1; mwb_rd_addr = 3'd3; mwb_result = 8'h5A;
        applyStimulus();
        nextCycle(); loadInstr(3'd3, 8'h33, 3'd4, 8'h44, 3'd5, 0);
        exm_valid = 1; exm_reg_we = 0; exm_rd_addr = 3'd3; exm_result = 8'hA5;
        applyStimulus();

        nextCycle(); loadInstr(3'd0, 8'hFF, 3'd2, 8'h22, 3'd1, 0);
        exm_valid = 1; exm_reg_we = 1; exm_rd_addr = 3'd0; exm_result = 8'h77;
        applyStimulus();
        nextCycle(); loadInstr(3'd1, 8'h10, 3'd6, 8'h66, 3'd1, 0);
        id_use_imm = 1; id_imm = 8'h3C;
        exm_valid = 1; exm_reg_we = 1; exm_rd_addr = 3'd6; exm_result = 8'h99;
        applyStimulus();

        nextCycle(); loadInstr(3'd2, 8'hC3, 3'd5, 8'h3C, 3'd7, 1); applyStimulus();
        for (int i = 0; i < 3; i++) begin
            nextCycle(); loadInstr(3'd4, 8'hEE, 3'd1, 8'hDD, 3'd2, 0);
            stall = 1; alu_flag = 4'b0110; applyStimulus();
        end
        nextCycle(); alu_flag = 4'b1001; applyStimulus();

        nextCycle(); loadInstr(3'd1, 8'h01, 3'd2, 8'h02, 3'd3, 1); applyStimulus();
        nextCycle(); stall = 1; alu_flag = 4'b0110; applyStimulus();
        nextCycle(); stall = 1; flush = 1; alu_flag = 4'b0101; applyStimulus();
        nextCycle(); loadInstr(3'd1, 8'h01, 3'd2, 8'h02, 3'd3, 1); applyStimulus();
        nextCycle(); flush = 1; alu_flag = 4'b0011; applyStimulus();

        nextCycle(); id_valid = 0; id_reg_we = 1; id_flag_we = 1;
        id_rs1_addr = 3'd5; id_rs1_data = 8'h55; applyStimulus();
        nextCycle(); alu_flag = 4'b1111; applyStimulus();

        for (int i = 0; i < 400; i++) begin
            nextCycle();
            rst         = ($urandom_range(0, 49) == 0);
            id_valid    = ($urandom_range(0, 4) != 0);
            id_rs1_addr = 3'($urandom_range(0, 7));
            id_rs2_addr = 3'($urandom_range(0, 7));
            id_rs1_data = 8'($urandom);
            id_rs2_data = 8'($urandom);
            id_imm      = 8'($urandom);
            id_use_imm  = ($urandom_range(0, 2) == 0);
            id_alu_sel  = 4'($urandom);
            id_rd_addr  = 3'($urandom_range(0, 7));
            id_reg_we   = ($urandom_range(0, 3) != 0);
            id_flag_we  = ($urandom_range(0, 1) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            exm_valid   = ($urandom_range(0, 3) != 0);
            exm_reg_we  = ($urandom_range(0, 3) != 0);
            exm_rd_addr = 3'($urandom_range(0, 3));
            exm_result  = 8'($urandom);
            mwb_valid   = ($urandom_range(0, 3) != 0);
            mwb_reg_we  = ($urandom_range(0, 3) != 0);
            mwb_rd_addr = 3'($urandom_range(0, 3));
            mwb_result  = 8'($urandom);
            alu_flag    = 4'($urandom);
            applyStimulus();
        end

        nextCycle();
        @(negedge clk);
        checkField("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
